// File: rtl/bm_weight_collector.sv
// bm_weight_collector: show-ahead FIFO that gathers BM weight beats off the read-return bus.
// Optional macro BM_SEQ_CHECK_EN enables per-beat sequence-number checking.
package bm_weight_collector_pkg;
    localparam int unsigned BM_READ_WIDTH = 4;
    localparam int unsigned TOKEN_W       = 4;
    localparam int unsigned BM_SIZE_W     = 16;
    localparam logic [1:0]  TYPE_BM       = 2'd1;

    typedef logic signed [7:0]     s_weight_t;
    typedef logic [TOKEN_W-1:0]    token_t;
    typedef logic [BM_SIZE_W-1:0]  bm_size_t;

    typedef struct packed {
        logic [1:0]                     dtype;
        token_t                         token;
        logic [7:0]                     seq;
        logic [7:0]                     len;
        s_weight_t [BM_READ_WIDTH-1:0]  data;
    } ReturnData_t;
endpackage

module bm_weight_collector
    import bm_weight_collector_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned OUT_MAX = DEPTH
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           pread_busValid,
    input  logic                           pread_isFeature,
    input  ReturnData_t                    data,
    input  token_t                         token,
    input  logic                           req_issue,
    input  logic                           clearReceivedBM,
    input  logic                           ren_fifo,
    output s_weight_t [BM_READ_WIDTH-1:0]  dataFifo,
    output logic                           empty_fifo,
    output logic                           can_request,
    output bm_size_t                       receivedBM,
    output logic [7:0]                     curSeq,
    output logic                           overflow_err,
    output logic                           seq_err
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = $clog2(OUT_MAX + 1);

    s_weight_t [BM_READ_WIDTH-1:0] r_mem [DEPTH];

    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [OW-1:0] r_out;
    bm_size_t      r_rcv;
    logic [7:0]    r_seq;
    logic          r_empty;
    logic          r_ovf;

    logic          w_match;
    logic          w_seq_ok;
    logic          w_full;
    logic          w_accept;
    logic          w_pop;
    logic          w_overflow;
    logic          w_out_inc;
    logic          w_out_dec;
    logic [CW-1:0] w_count_nxt;
    logic [31:0]   w_sum;

    assign w_match = pread_busValid && !pread_isFeature &&
                     (data.dtype == TYPE_BM) && (data.token == token);

`ifdef BM_SEQ_CHECK_EN
    logic r_serr;
    assign w_seq_ok = (data.seq == r_seq);

    // Sticky flag for beats arriving out of order.
    always_ff @(posedge clock) begin
        if (reset || clearReceivedBM) begin
            r_serr <= 1'b0;
        end else if (w_match && !w_seq_ok) begin
            r_serr <= 1'b1;
        end
    end
    assign seq_err = r_serr;
`else
    logic w_unused_seq;
    assign w_unused_seq = ^data.seq;
    assign w_seq_ok     = 1'b1;
    assign seq_err      = 1'b0;
`endif

    // A full FIFO still takes a beat when the same cycle frees a slot.
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_pop      = ren_fifo && !r_empty;
    assign w_accept   = w_match && w_seq_ok && (!w_full || ren_fifo);
    assign w_overflow = w_match && w_seq_ok && w_full && !ren_fifo;
    assign w_out_inc  = req_issue && !w_accept && (r_out != OW'(OUT_MAX));
    assign w_out_dec  = w_accept && !req_issue && (r_out != '0);

    always_comb begin
        w_count_nxt = r_count;
        if (w_accept && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_accept && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clearReceivedBM) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_out    <= '0;
            r_rcv    <= '0;
            r_seq    <= '0;
            r_empty  <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                r_seq    <= r_seq + 8'd1;
                r_rcv    <= r_rcv + bm_size_t'(data.len);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_out_inc) begin
                r_out <= r_out + OW'(1);
            end else if (w_out_dec) begin
                r_out <= r_out - OW'(1);
            end
            if (w_overflow) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Storage is not reset; validity is tracked by the count and pointers.
    always_ff @(posedge clock) begin
        if (!reset && !clearReceivedBM && w_accept) begin
            r_mem[r_wr_ptr] <= data.data;
        end
    end

    assign w_sum        = 32'(r_count) + 32'(r_out);
    assign can_request  = (w_sum < DEPTH) && (32'(r_out) < OUT_MAX);
    assign dataFifo     = r_empty ? '0 : r_mem[r_rd_ptr];
    assign empty_fifo   = r_empty;
    assign receivedBM   = r_rcv;
    assign curSeq       = r_seq;
    assign overflow_err = r_ovf;
endmodule

// File: tb/tb_bm_weight_collector.sv
// Directed bench for bm_weight_collector: queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
`timescale 1ns/1ps
module tb_bm_weight_collector;
    import bm_weight_collector_pkg::*;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned OUT_MAX = 8;
    localparam logic [3:0]  TOK     = 4'h3;

    logic        clock = 1'b0;
    logic        reset;
    logic        pread_busValid;
    logic        pread_isFeature;
    ReturnData_t data;
    token_t      token;
    logic        req_issue;
    logic        clearReceivedBM;
    logic        ren_fifo;
    s_weight_t [BM_READ_WIDTH-1:0] dataFifo;
    logic        empty_fifo;
    logic        can_request;
    bm_size_t    receivedBM;
    logic [7:0]  curSeq;
    logic        overflow_err;
    logic        seq_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_q[$];
    int          m_out  = 0;
    int          m_rcv  = 0;
    int          m_seq  = 0;
    logic        m_ovf  = 1'b0;
    logic        m_serr = 1'b0;
    logic        m_live = 1'b0;

    bm_weight_collector #(.DEPTH(DEPTH), .OUT_MAX(OUT_MAX)) dut (
        .clock           (clock),
        .reset           (reset),
        .pread_busValid  (pread_busValid),
        .pread_isFeature (pread_isFeature),
        .data            (data),
        .token           (token),
        .req_issue       (req_issue),
        .clearReceivedBM (clearReceivedBM),
        .ren_fifo        (ren_fifo),
        .dataFifo        (dataFifo),
        .empty_fifo      (empty_fifo),
        .can_request     (can_request),
        .receivedBM      (receivedBM),
        .curSeq          (curSeq),
        .overflow_err    (overflow_err),
        .seq_err         (seq_err)
    );

    always #5 clock = ~clock;

    // Model: FIFO as a queue, counters as plain integers.
    always @(posedge clock) begin
        logic match, seq_ok, pop, acc;
        int   sz;
        if (reset || clearReceivedBM) begin
            m_q.delete();
            m_out  = 0;
            m_rcv  = 0;
            m_seq  = 0;
            m_ovf  = 1'b0;
            m_serr = 1'b0;
            m_live = 1'b1;
        end else begin
            sz    = m_q.size();
            match = pread_busValid && !pread_isFeature &&
                    (data.dtype == TYPE_BM) && (data.token == token);
`ifdef BM_SEQ_CHECK_EN
            seq_ok = (int'(data.seq) == m_seq);
`else
            seq_ok = 1'b1;
`endif
            pop = ren_fifo && (sz > 0);
            acc = match && seq_ok && ((sz < int'(DEPTH)) || ren_fifo);
            if (match && seq_ok && !acc) m_ovf = 1'b1;
            if (match && !seq_ok) m_serr = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                m_q.push_back(data.data);
                m_rcv = (m_rcv + int'(data.len)) % 65536;
                m_seq = (m_seq + 1) % 256;
            end
            if (req_issue && !acc && m_out < int'(OUT_MAX)) m_out = m_out + 1;
            else if (acc && !req_issue && m_out > 0) m_out = m_out - 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [31:0] exp_head;
        logic        exp_can;
        exp_head = (m_q.size() == 0) ? 32'h0 : m_q[0];
        exp_can  = ((m_q.size() + m_out) < int'(DEPTH)) && (m_out < int'(OUT_MAX));
        chk("model.empty_fifo",   32'(empty_fifo),   32'(m_q.size() == 0));
        chk("model.dataFifo",     dataFifo,          exp_head);
        chk("model.can_request",  32'(can_request),  32'(exp_can));
        chk("model.receivedBM",   32'(receivedBM),   32'(m_rcv));
        chk("model.curSeq",       32'(curSeq),       32'(m_seq));
        chk("model.overflow_err", 32'(overflow_err), 32'(m_ovf));
        chk("model.seq_err",      32'(seq_err),      32'(m_serr));
    endtask

    function automatic logic [31:0] pat(input int k);
        pat = {4{8'(k)}};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        pread_busValid  = 1'b0;
        pread_isFeature = 1'b0;
        req_issue       = 1'b0;
        clearReceivedBM = 1'b0;
        ren_fifo        = 1'b0;
    endtask

    task automatic beat(input int sq, input int ln, input logic [31:0] w);
        pread_busValid  = 1'b1;
        pread_isFeature = 1'b0;
        data.dtype      = TYPE_BM;
        data.token      = TOK;
        data.seq        = 8'(sq);
        data.len        = 8'(ln);
        data.data       = w;
    endtask

    initial begin
        reset           = 1'b1;
        pread_busValid  = 1'b0;
        pread_isFeature = 1'b0;
        req_issue       = 1'b0;
        clearReceivedBM = 1'b0;
        ren_fifo        = 1'b0;
        data            = '0;
        token           = TOK;

        fork
            forever begin
                @(negedge clock);
                if (m_live) compare_all();
            end
        join_none

        // Traffic during reset must be ignored
        beat(0, 2, pat(9)); ren_fifo = 1'b1; req_issue = 1'b1; tick();
        beat(0, 2, pat(9)); ren_fifo = 1'b1; req_issue = 1'b1; tick();
        reset = 1'b0;
        chk("reset.empty_fifo",   32'(empty_fifo),   32'd1);
        chk("reset.can_request",  32'(can_request),  32'd1);
        chk("reset.dataFifo",     dataFifo,          32'h0);
        chk("reset.receivedBM",   32'(receivedBM),   32'd0);
        chk("reset.curSeq",       32'(curSeq),       32'd0);
        chk("reset.overflow_err", 32'(overflow_err), 32'd0);
        chk("reset.seq_err",      32'(seq_err),      32'd0);

        // Three beats, first visible one cycle after acceptance
        beat(0, 2, pat(1)); tick();
        chk("first.empty_fifo", 32'(empty_fifo), 32'd0);
        chk("first.dataFifo",   dataFifo,        32'h01010101);
        beat(1, 2, pat(2)); tick();
        beat(2, 2, pat(3)); tick();
        chk("three.receivedBM", 32'(receivedBM), 32'd6);
        chk("three.curSeq",     32'(curSeq),     32'd3);
        chk("three.dataFifo",   dataFifo,        32'h01010101);

        // Non-matching beats: wrong token, feature data, wrong type
        beat(3, 2, pat(7)); data.token = 4'hA; tick();
        beat(3, 2, pat(7)); pread_isFeature = 1'b1; tick();
        beat(3, 2, pat(7)); data.dtype = 2'd2; tick();
        chk("nomatch.receivedBM", 32'(receivedBM), 32'd6);
        chk("nomatch.curSeq",     32'(curSeq),     32'd3);

        // Outstanding requests throttle can_request
        for (int i = 0; i < 5; i++) begin
            req_issue = 1'b1; tick();
        end
        chk("credit.blocked", 32'(can_request), 32'd0);
        beat(3, 2, pat(4)); tick();
        chk("credit.after_beat", 32'(can_request), 32'd0);
        ren_fifo = 1'b1; tick();
        chk("credit.after_pop", 32'(can_request), 32'd1);
        chk("credit.dataFifo",  dataFifo,         32'h02020202);

        // Clear together with a matching beat at count=5
        beat(4, 2, pat(5)); tick();
        beat(5, 2, pat(6)); tick();
        beat(6, 2, pat(8)); clearReceivedBM = 1'b1; tick();
        chk("clear.empty_fifo", 32'(empty_fifo), 32'd1);
        chk("clear.receivedBM", 32'(receivedBM), 32'd0);
        chk("clear.curSeq",     32'(curSeq),     32'd0);
        chk("clear.dataFifo",   dataFifo,        32'h0);

        // Fill, then overflow, then full beat with simultaneous pop
        for (int k = 0; k < 8; k++) begin
            beat(k, 2, pat(16 + k)); tick();
        end
        chk("full.can_request", 32'(can_request), 32'd0);
        beat(8, 2, pat(24)); tick();
        chk("ovf.flag",       32'(overflow_err), 32'd1);
        chk("ovf.curSeq",     32'(curSeq),       32'd8);
        chk("ovf.receivedBM", 32'(receivedBM),   32'd16);
        beat(8, 2, pat(24)); ren_fifo = 1'b1; tick();
        chk("fullpop.curSeq",   32'(curSeq), 32'd9);
        chk("fullpop.dataFifo", dataFifo,    32'h11111111);

        // Stream until curSeq wraps 255 -> 0
        for (int i = 0; i < 247; i++) begin
            beat(9 + i, 2, pat(i)); ren_fifo = 1'b1; tick();
        end
        chk("wrap.curSeq",       32'(curSeq),       32'd0);
        chk("wrap.receivedBM",   32'(receivedBM),   32'd512);
        chk("wrap.dataFifo",     dataFifo,          32'hEFEFEFEF);
        chk("wrap.overflow_err", 32'(overflow_err), 32'd1);

        // Drain, then pop on empty
        for (int i = 0; i < 8; i++) begin
            ren_fifo = 1'b1; tick();
        end
        ren_fifo = 1'b1; tick();
        chk("drain.empty_fifo", 32'(empty_fifo), 32'd1);
        chk("drain.dataFifo",   dataFifo,        32'h0);

        // Beat and pop together on an empty FIFO
        beat(0, 2, pat(8'h5A)); ren_fifo = 1'b1; tick();
        chk("emptypop.empty_fifo", 32'(empty_fifo), 32'd0);
        chk("emptypop.dataFifo",   dataFifo,        32'h5A5A5A5A);
        ren_fifo = 1'b1; tick();

        // Outstanding saturates at OUT_MAX
        for (int i = 0; i < 10; i++) begin
            req_issue = 1'b1; tick();
        end
        chk("sat.can_request", 32'(can_request), 32'd0);
        beat(1, 1, pat(3)); tick();
        tick();

        // Sequence check behaviour
        clearReceivedBM = 1'b1; tick();
        chk("clr2.overflow_err", 32'(overflow_err), 32'd0);
        for (int k = 0; k < 4; k++) begin
            beat(k, 1, pat(k)); tick();
        end
        beat(5, 1, pat(5)); tick();
`ifdef BM_SEQ_CHECK_EN
        chk("seq.err",        32'(seq_err),    32'd1);
        chk("seq.curSeq",     32'(curSeq),     32'd4);
        chk("seq.receivedBM", 32'(receivedBM), 32'd4);
`else
        chk("seq.err",        32'(seq_err),    32'd0);
        chk("seq.curSeq",     32'(curSeq),     32'd5);
        chk("seq.receivedBM", 32'(receivedBM), 32'd5);
`endif
        clearReceivedBM = 1'b1; tick();
        chk("clr3.seq_err", 32'(seq_err), 32'd0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
